ddr2_init_mon: RTL and testbench

DDR2_INIT_MON -- requirements
Module: ddr2_init_mon

---
 rtl/ddr2_init_mon.sv | 196 +++++++++++++++++++
 tb/tb_ddr2_init_mon.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ddr2_init_mon.sv
// Passive checker of the DDR2 power-up/init command order, fields and sticky first error; results registered one edge after the sample.
// Define DDR2_INIT_MON_TIMING_EN to add the inter-command gap counter and the timing-violation check (code 3).
module ddr2_init_mon #(
  parameter int BA_BITS     = 3,
  parameter int ADDR_BITS   = 14,
  parameter int CKE_WAIT_CK = 100,
  parameter int TRP_CK      = 3,
  parameter int TMRD_CK     = 2,
  parameter int TRFC_CK     = 26
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cke,
  input  logic [3:0]           cmd,
  input  logic [BA_BITS-1:0]   ba,
  input  logic [ADDR_BITS-1:0] addr,
  output logic [ADDR_BITS-1:0] mr_q,
  output logic [ADDR_BITS-1:0] emr1_q,
  output logic [ADDR_BITS-1:0] emr2_q,
  output logic [ADDR_BITS-1:0] emr3_q,
  output logic [2:0]           cl,
  output logic [2:0]           al,
  output logic                 dev_ready,
  output logic                 err,
  output logic [2:0]           err_code
);

  typedef enum logic [2:0] {C_NOP, C_PRE, C_AREF, C_LM, C_ILL} cmd_e;
  typedef enum logic [3:0] {
    WAIT_CKE, WAIT_NOP, PRE_A, EMR2, EMR3, EMR1A, MRA, PRE_B,
    AREF1, AREF2, MRB, EMR1B, EMR1C, READY, ERROR
  } state_e;

  localparam int CW = $clog2(CKE_WAIT_CK + 1);

  state_e         state_q, state_d, nxt;
  cmd_e           dec, exp_c;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     code_d;
  logic           err_d;
  logic [ADDR_BITS-1:0] mr_d, emr1_d, emr2_d, emr3_d;
  logic [BA_BITS-1:0]   exp_ba;
  logic           ba_chk, fld_ok, active, expecting, ba_bad;
  logic           e1, e2, e3, e4, e5, e6;

  always_comb begin
    dec = C_ILL;
    if (cmd[3] || cmd == 4'b0111) dec = C_NOP;
    else if (cmd == 4'b0010)      dec = C_PRE;
    else if (cmd == 4'b0001)      dec = C_AREF;
    else if (cmd == 4'b0000)      dec = C_LM;
  end

  // What each expecting state wants to see, and where it goes on acceptance
  always_comb begin
    exp_c  = C_LM;
    exp_ba = '0;
    ba_chk = 1'b1;
    fld_ok = 1'b1;
    nxt    = state_q;
    case (state_q)
      PRE_A:   begin exp_c = C_PRE; ba_chk = 1'b0; fld_ok = addr[10]; nxt = EMR2; end
      EMR2:    begin exp_ba = BA_BITS'(2); nxt = EMR3; end
      EMR3:    begin exp_ba = BA_BITS'(3); nxt = EMR1A; end
      EMR1A:   begin exp_ba = BA_BITS'(1); nxt = MRA; end
      MRA:     begin fld_ok = addr[8]; nxt = PRE_B; end
      PRE_B:   begin exp_c = C_PRE; ba_chk = 1'b0; fld_ok = addr[10]; nxt = AREF1; end
      AREF1:   begin exp_c = C_AREF; ba_chk = 1'b0; nxt = AREF2; end
      AREF2:   begin exp_c = C_AREF; ba_chk = 1'b0; nxt = MRB; end
      MRB:     nxt = EMR1B;
      EMR1B:   begin exp_ba = BA_BITS'(1); fld_ok = (addr[9:7] == 3'b111); nxt = EMR1C; end
      EMR1C:   begin exp_ba = BA_BITS'(1); fld_ok = (addr[9:7] == 3'b000); nxt = READY; end
      default: ;
    endcase
  end

  assign active    = !(state_q inside {WAIT_CKE, READY, ERROR});
  assign expecting = active && (state_q != WAIT_NOP);
  assign ba_bad    = ba_chk && (ba != exp_ba);
  assign e6 = active && !cke;
  assign e5 = active && (dec == C_ILL);
  assign e1 = (state_q == WAIT_NOP) && (dec != C_NOP);
  assign e2 = expecting && (dec != C_NOP) && (dec != C_ILL) && ((dec != exp_c) || ba_bad);
  assign e4 = expecting && (dec == exp_c) && !ba_bad && !fld_ok;

`ifdef DDR2_INIT_MON_TIMING_EN
  localparam int GW = $clog2(TRFC_CK + 1);
  logic [GW-1:0] gap_q, gap_d;
  cmd_e          last_q, last_d;
  logic          last_vld_q, last_vld_d;
  int            tlast;

  // gap_q is distance-1 from the previous command, so a violation is gap_q+1 < t
  always_comb begin
    gap_d      = gap_q;
    last_d     = last_q;
    last_vld_d = last_vld_q;
    if (dec != C_NOP) begin
      gap_d = '0;
      if (dec != C_ILL) begin
        last_d     = dec;
        last_vld_d = 1'b1;
      end
    end else if (int'(gap_q) < TRFC_CK) begin
      gap_d = gap_q + GW'(1);
    end
    case (last_q)
      C_PRE:   tlast = TRP_CK;
      C_LM:    tlast = TMRD_CK;
      C_AREF:  tlast = TRFC_CK;
      default: tlast = 0;
    endcase
    e3 = active && last_vld_q && (dec != C_NOP) && (dec != C_ILL) && (int'(gap_q) + 1 < tlast);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q      <= '0;
      last_q     <= C_NOP;
      last_vld_q <= 1'b0;
    end else begin
      gap_q      <= gap_d;
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
    end
  end
`else
  assign e3 = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err;
    code_d  = err_code;
    mr_d    = mr_q;
    emr1_d  = emr1_q;
    emr2_d  = emr2_q;
    emr3_d  = emr3_q;
    if (state_q == WAIT_CKE) begin
      cnt_d = '0;
      if (cke) state_d = WAIT_NOP;
    end else if (active) begin
      if (e6 || e5 || e1 || e2 || e4 || e3) begin
        state_d = ERROR;
        err_d   = 1'b1;
        if (e6)      code_d = 3'd6;
        else if (e5) code_d = 3'd5;
        else if (e1) code_d = 3'd1;
        else if (e2) code_d = 3'd2;
        else if (e4) code_d = 3'd4;
        else         code_d = 3'd3;
      end else if (state_q == WAIT_NOP) begin
        if (cnt_q == CW'(CKE_WAIT_CK - 1)) state_d = PRE_A;
        else                               cnt_d   = cnt_q + CW'(1);
      end else if (dec == exp_c) begin
        state_d = nxt;
        if (dec == C_LM) begin
          case (ba[1:0])
            2'd0:    mr_d   = addr;
            2'd1:    emr1_d = addr;
            2'd2:    emr2_d = addr;
            default: emr3_d = addr;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT_CKE;
      cnt_q    <= '0;
      err      <= 1'b0;
      err_code <= 3'd0;
      mr_q     <= '0;
      emr1_q   <= '0;
      emr2_q   <= '0;
      emr3_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err      <= err_d;
      err_code <= code_d;
      mr_q     <= mr_d;
      emr1_q   <= emr1_d;
      emr2_q   <= emr2_d;
      emr3_q   <= emr3_d;
    end
  end

  assign dev_ready = (state_q == READY);
  assign cl        = mr_q[6:4];
  assign al        = emr1_q[5:3];

endmodule

// File: tb/tb_ddr2_init_mon.sv
// Directed bench for ddr2_init_mon: legal init, each error code, sticky errors and async reset.
module tb_ddr2_init_mon;

  logic        clk;
  logic        rst_n;
  logic        cke;
  logic [3:0]  cmd;
  logic [2:0]  ba;
  logic [13:0] addr;
  logic [13:0] mr_q, emr1_q, emr2_q, emr3_q;
  logic [2:0]  cl, al, err_code;
  logic        dev_ready, err;

  int n_cmp = 0;
  int n_mis = 0;

  ddr2_init_mon dut (
    .clk(clk), .rst_n(rst_n), .cke(cke), .cmd(cmd), .ba(ba), .addr(addr),
    .mr_q(mr_q), .emr1_q(emr1_q), .emr2_q(emr2_q), .emr3_q(emr3_q),
    .cl(cl), .al(al), .dev_ready(dev_ready), .err(err), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, DUT samples on the rising edge, results read at the next falling edge
  task automatic cyc(input logic k, input logic [3:0] c, input logic [2:0] b, input logic [13:0] a);
    cke = k; cmd = c; ba = b; addr = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 4'b0111, 3'd0, 14'h0);
  endtask

  task automatic pre(input logic [13:0] a);  cyc(1'b1, 4'b0010, 3'd0, a); endtask
  task automatic aref();                     cyc(1'b1, 4'b0001, 3'd0, 14'h0); endtask
  task automatic lm(input logic [2:0] b, input logic [13:0] a); cyc(1'b1, 4'b0000, b, a); endtask

  task automatic do_reset();
    rst_n = 1'b0; cke = 1'b0; cmd = 4'b1111; ba = '0; addr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // cke low for a few cycles, one rising cycle, then the minimum NOP wait; leaves the DUT in PRE_A
  task automatic power_up();
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b1111, 3'd0, 14'h0);
    cyc(1'b1, 4'b1111, 3'd0, 14'h0);
    for (int i = 0; i < 100; i++) cyc(1'b1, 4'b1111, 3'd0, 14'h0);
  endtask

  // PRE_A through MRA at minimum spacing; leaves the DUT in PRE_B
  task automatic front();
    pre(14'h400); nop(2);
    lm(3'd2, 14'h0); nop(1);
    lm(3'd3, 14'h0); nop(1);
    lm(3'd1, 14'h0); nop(1);
    lm(3'd0, 14'h100); nop(1);
  endtask

  task automatic tail(input int aref_gap);
    pre(14'h400); nop(2);
    aref(); nop(aref_gap - 1);
    aref(); nop(25);
    lm(3'd0, 14'h0432); nop(1);
    lm(3'd1, 14'h0380); nop(1);
  endtask

  initial begin
    rst_n = 1'b0; cke = 1'b0; cmd = 4'b1111; ba = '0; addr = '0;
    repeat (2) @(negedge clk);
    check("rst_dev_ready", 32'(dev_ready), 0);
    check("rst_err", 32'(err), 0);
    check("rst_err_code", 32'(err_code), 0);
    check("rst_mr", 32'(mr_q), 0);
    rst_n = 1'b1;

    // Legal sequence at exact minimum spacings
    power_up();
    front();
    check("mra_loaded", 32'(mr_q), 32'h100);
    tail(26);
    check("ready_before_emr1c", 32'(dev_ready), 0);
    lm(3'd1, 14'h010);
    check("legal_dev_ready", 32'(dev_ready), 1);
    check("legal_cl", 32'(cl), 3);
    check("legal_al", 32'(al), 2);
    check("legal_err", 32'(err), 0);
    check("legal_mr", 32'(mr_q), 32'h432);
    check("legal_emr1", 32'(emr1_q), 32'h010);
    // READY ignores illegal codes and cke low
    cyc(1'b0, 4'b0101, 3'd0, 14'h0);
    pre(14'h0);
    check("ready_hold", 32'(dev_ready), 1);
    check("ready_no_err", 32'(err), 0);

    // Early PRE, 50 cycles after cke rise
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b1111, 3'd0, 14'h0);
    cyc(1'b1, 4'b1111, 3'd0, 14'h0);
    nop(49);
    check("early_no_err_yet", 32'(err), 0);
    pre(14'h400);
    check("early_err", 32'(err), 1);
    check("early_code", 32'(err_code), 1);
    cyc(1'b0, 4'b0101, 3'd0, 14'h0);
    nop(60);
    check("early_code_sticky", 32'(err_code), 1);
    check("early_never_ready", 32'(dev_ready), 0);

    // AREF2 only 20 cycles after AREF1
    do_reset();
    power_up();
    front();
    tail(20);
`ifdef DDR2_INIT_MON_TIMING_EN
    check("trfc_code", 32'(err_code), 3);
    lm(3'd1, 14'h010);
    check("trfc_not_ready", 32'(dev_ready), 0);
`else
    check("trfc_no_err", 32'(err), 0);
    lm(3'd1, 14'h010);
    check("trfc_ready", 32'(dev_ready), 1);
`endif

    // LM to EMR1 while EMR2 is expected
    do_reset();
    power_up();
    pre(14'h400); nop(2);
    lm(3'd1, 14'h1234);
    check("wrong_ba_code", 32'(err_code), 2);
    check("wrong_ba_emr1", 32'(emr1_q), 0);

    // PRE_A with A10 low
    do_reset();
    power_up();
    pre(14'h000);
    check("a10_code", 32'(err_code), 4);

    // Illegal code in WAIT_NOP outranks early command
    do_reset();
    cyc(1'b1, 4'b1111, 3'd0, 14'h0);
    nop(10);
    cyc(1'b1, 4'b0101, 3'd0, 14'h0);
    check("illegal_code", 32'(err_code), 5);

    // cke drop together with an illegal code in PRE_B
    do_reset();
    power_up();
    front();
    cyc(1'b0, 4'b0101, 3'd0, 14'h0);
    check("cke_drop_code", 32'(err_code), 6);
    check("cke_drop_err", 32'(err), 1);

    // Asynchronous reset while waiting in AREF1, then a full legal run
    do_reset();
    power_up();
    front();
    pre(14'h400); nop(1);
    check("aref1_mr_before", 32'(mr_q), 32'h100);
    rst_n = 1'b0;
    #1;
    check("async_rst_mr", 32'(mr_q), 0);
    check("async_rst_err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    power_up();
    front();
    tail(26);
    lm(3'd1, 14'h010);
    check("rerun_ready", 32'(dev_ready), 1);
    check("rerun_err", 32'(err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
